puf_avmm_ctrl: RTL and testbench

PUF_AVMM_CTRL -- requirements
Module: puf_avmm_ctrl

---
 rtl/puf_avmm_ctrl_if.sv | 25 ++
 rtl/puf_avmm_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_puf_avmm_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/puf_avmm_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : puf_avmm_ctrl_if
// Purpose  : Avalon-MM slave register bus between the HPS bridge and the PUF controller
// Revision : 1.0
// ============================================================================
interface puf_avmm_ctrl_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_readdatavalid
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_readdatavalid
  );
endinterface
`default_nettype wire

// File: rtl/puf_avmm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : puf_avmm_ctrl
// Purpose  : Sequences challenge/fire/capture over a PUF core, one response bit per run step
// Revision : 1.0
// ============================================================================
module puf_avmm_ctrl #(
  parameter int RESP_BITS      = 32,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  wire logic        clk,
  input  wire logic        reset,
  puf_avmm_ctrl_if.slave   avs,
  output logic [63:0]      puf_challenge,
  output logic             puf_start,
  input  wire logic        puf_done,
  input  wire logic        puf_bit,
  output logic             irq
);

  localparam logic [31:0] c_ID = 32'h5055_4631;
  localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int c_CNT_W = (c_TMO_W > 8) ? c_TMO_W : 8;
  localparam logic [c_CNT_W-1:0] c_SETTLE_LAST  = c_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]  c_LAST_BIT  = 5'(RESP_BITS - 1);
  localparam logic [31:0] c_RESP_MASK = (RESP_BITS >= 32) ? 32'hFFFF_FFFF
                                                          : ((32'h1 << RESP_BITS) - 32'h1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_FIRE    = 3'd2,
    S_WAIT    = 3'd3,
    S_CAPTURE = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [4:0]          r_idx, w_idx_nxt;
  logic                r_irq_en, r_done, r_timeout, r_irq;
  logic [31:0]         r_chal_lo, r_chal_hi, r_response;
  logic [31:0]         r_rdata;
  logic                r_rvalid;

  logic w_start_go, w_set_done, w_set_timeout, w_capture;
  logic w_wr_ctrl, w_wr_status, w_wr_lo, w_wr_hi, w_idle;
  logic w_done_nxt, w_timeout_nxt, w_irq_en_nxt;
  logic [63:0] w_chal;
  logic [31:0] w_rd_mux;

  assign w_idle      = (r_state == S_IDLE);
  assign w_wr_ctrl   = avs.avs_write && (avs.avs_address == 3'd0);
  assign w_wr_status = avs.avs_write && (avs.avs_address == 3'd1);
  assign w_wr_lo     = avs.avs_write && (avs.avs_address == 3'd2);
  assign w_wr_hi     = avs.avs_write && (avs.avs_address == 3'd3);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_start_go    = 1'b0;
    w_set_done    = 1'b0;
    w_set_timeout = 1'b0;
    w_capture     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_wr_ctrl && avs.avs_writedata[0]) begin
          w_start_go  = 1'b1;
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      end
      S_SETTLE: begin
        if (r_cnt == c_SETTLE_LAST) begin
          w_state_nxt = S_FIRE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_FIRE: begin
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = '0;
      end
      S_WAIT: begin
        // A completion on the final wait cycle still counts as success.
        if (puf_done) begin
          w_state_nxt = S_CAPTURE;
        end else if (r_cnt == c_TIMEOUT_LAST) begin
          w_set_timeout = 1'b1;
          w_state_nxt   = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_CAPTURE: begin
        w_capture = 1'b1;
        if (r_idx == c_LAST_BIT) begin
          w_set_done  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_idx_nxt   = r_idx + 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SETTLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sticky flags: a set in the same cycle as a W1C clear wins.
  assign w_done_nxt    = w_set_done |
                         (r_done & ~(w_start_go | (w_wr_status & avs.avs_writedata[1])));
  assign w_timeout_nxt = w_set_timeout |
                         (r_timeout & ~(w_start_go | (w_wr_status & avs.avs_writedata[2])));
  assign w_irq_en_nxt  = w_wr_ctrl ? avs.avs_writedata[1] : r_irq_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_irq_en   <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_irq      <= 1'b0;
      r_chal_lo  <= '0;
      r_chal_hi  <= '0;
      r_response <= '0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_irq_en  <= w_irq_en_nxt;
      r_done    <= w_done_nxt;
      r_timeout <= w_timeout_nxt;
      r_irq     <= w_irq_en_nxt & (w_done_nxt | w_timeout_nxt);
      if (w_wr_lo && w_idle) r_chal_lo <= avs.avs_writedata;
      if (w_wr_hi && w_idle) r_chal_hi <= avs.avs_writedata;
      if (w_start_go) begin
        r_response <= '0;
      end else if (w_capture) begin
        r_response[r_idx] <= puf_bit;
      end
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (avs.avs_address)
      3'd0:    w_rd_mux = {30'd0, r_irq_en, 1'b0};
      3'd1:    w_rd_mux = {29'd0, r_timeout, r_done, ~w_idle};
      3'd2:    w_rd_mux = r_chal_lo;
      3'd3:    w_rd_mux = r_chal_hi;
      3'd4:    w_rd_mux = r_response & c_RESP_MASK;
      3'd5:    w_rd_mux = c_ID;
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= avs.avs_read;
      r_rdata  <= avs.avs_read ? w_rd_mux : 32'd0;
    end
  end

  // Rotate-left by the bit index; a shift of 64 yields zero so index 0 is a pass-through.
  assign w_chal        = {r_chal_hi, r_chal_lo};
  assign puf_challenge = (w_chal << r_idx) | (w_chal >> (7'd64 - {2'b00, r_idx}));
  assign puf_start     = (r_state == S_FIRE);
  assign irq           = r_irq;

  assign avs.avs_readdata      = r_rdata;
  assign avs.avs_readdatavalid = r_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_puf_avmm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_puf_avmm_ctrl
// Purpose  : Scoreboard bench for puf_avmm_ctrl with a fixed-latency PUF core model
// Revision : 1.0
// ============================================================================
module tb_puf_avmm_ctrl;
  localparam int c_SETTLE  = 16;
  localparam int c_TIMEOUT = 1024;
  localparam int c_RUN     = 700;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] puf_challenge;
  logic        puf_start, puf_done, puf_bit, irq;

  puf_avmm_ctrl_if bus ();

  puf_avmm_ctrl #(
    .RESP_BITS     (32),
    .SETTLE_CYCLES (c_SETTLE),
    .TIMEOUT_CYCLES(c_TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .avs          (bus),
    .puf_challenge(puf_challenge),
    .puf_start    (puf_start),
    .puf_done     (puf_done),
    .puf_bit      (puf_bit),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [34:0] sb_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // PUF core model: completes 3 cycles after each fire, response bit = fire index LSB.
  logic        model_en, model_clr;
  int          fire_cnt = 0;
  int          dly = 0;
  logic        pend_bit = 1'b0;
  logic [63:0] chal_seen [0:31];

  always @(negedge clk) begin
    puf_done = 1'b0;
    if (model_clr) begin
      fire_cnt = 0;
      dly      = 0;
    end else begin
      if (dly != 0) begin
        dly--;
        if (dly == 0 && model_en) begin
          puf_done = 1'b1;
          puf_bit  = pend_bit;
        end
      end
      if (puf_start) begin
        if (fire_cnt < 32) chal_seen[fire_cnt] = puf_challenge;
        pend_bit = fire_cnt[0];
        fire_cnt++;
        dly = 3;
      end
    end
  end

  // Read-return monitor: exactly one valid per read, one cycle later, data from the scoreboard.
  logic        rd_prev;
  logic [34:0] sb_item;
  always @(posedge clk) begin
    rd_prev = bus.avs_read;
    #1;
    if (rd_prev || bus.avs_readdatavalid) begin
      check("rvalid", {63'd0, bus.avs_readdatavalid}, {63'd0, rd_prev});
      if (rd_prev && bus.avs_readdatavalid) begin
        if (sb_q.size() == 0) begin
          check("sb_pop", 64'(sb_q.size()), 64'd1);
        end else begin
          sb_item = sb_q.pop_front();
          check($sformatf("rdata@%0d", sb_item[34:32]),
                {32'd0, bus.avs_readdata}, {32'd0, sb_item[31:0]});
        end
      end
    end
  end

  // Bus tasks are entered and left on a falling edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    @(negedge clk);
    bus.avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] exp);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    sb_q.push_back({a, exp});
    @(negedge clk);
    bus.avs_read    = 1'b0;
  endtask

  task automatic clear_model();
    model_clr = 1'b1;
    repeat (2) @(negedge clk);
    model_clr = 1'b0;
  endtask

  task automatic check_full_run(input string tag);
    check({tag, "_fires"}, 64'(fire_cnt), 64'd32);
    check({tag, "_chal0"}, chal_seen[0], 64'h1);
    check({tag, "_chal1"}, chal_seen[1], 64'h2);
    check({tag, "_chal31"}, chal_seen[31], 64'h8000_0000);
    bus_read(3'd4, 32'hAAAA_AAAA);
    bus_read(3'd1, 32'h2);
  endtask

  initial begin
    reset = 1'b1;
    bus.avs_address = '0;
    bus.avs_read = 1'b0;
    bus.avs_write = 1'b0;
    bus.avs_writedata = '0;
    puf_done = 1'b0;
    puf_bit = 1'b0;
    model_en = 1'b1;
    model_clr = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_start", {63'd0, puf_start}, 64'd0);
    check("rst_chal", puf_challenge, 64'd0);
    check("rst_irq", {63'd0, irq}, 64'd0);
    check("rst_rvalid", {63'd0, bus.avs_readdatavalid}, 64'd0);
    check("rst_rdata", {32'd0, bus.avs_readdata}, 64'd0);
    reset = 1'b0;
    model_clr = 1'b0;
    @(negedge clk);

    // Register map after reset, unmapped addresses
    bus_read(3'd0, 32'h0);
    bus_read(3'd1, 32'h0);
    bus_read(3'd2, 32'h0);
    bus_read(3'd3, 32'h0);
    bus_read(3'd4, 32'h0);
    bus_read(3'd5, 32'h5055_4631);
    bus_read(3'd7, 32'h0);
    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_read(3'd6, 32'h0);

    // Full run with irq enabled
    bus_write(3'd2, 32'h1);
    bus_write(3'd3, 32'h0);
    bus_read(3'd2, 32'h1);
    bus_write(3'd0, 32'h3);
    bus_read(3'd1, 32'h1);
    bus_read(3'd0, 32'h2);
    repeat (c_RUN) @(negedge clk);
    check_full_run("run1");
    check("irq_set", {63'd0, irq}, 64'd1);
    bus_write(3'd1, 32'h2);
    check("irq_clr", {63'd0, irq}, 64'd0);
    bus_read(3'd1, 32'h0);

    // Timeout: core never answers
    model_en = 1'b0;
    bus_write(3'd0, 32'h1);
    repeat (c_SETTLE + c_TIMEOUT) @(negedge clk);
    bus_read(3'd1, 32'h1);
    bus_read(3'd1, 32'h4);
    bus_read(3'd4, 32'h0);
    check("tmo_irq", {63'd0, irq}, 64'd0);
    bus_write(3'd1, 32'h4);
    bus_read(3'd1, 32'h0);
    model_en = 1'b1;

    // Restart and challenge writes while busy must be ignored
    clear_model();
    bus_write(3'd0, 32'h1);
    repeat (27) @(negedge clk);
    bus_write(3'd0, 32'h1);
    bus_write(3'd2, 32'h0000_FFFF);
    check("busy_chal", puf_challenge, 64'h2);
    repeat (c_RUN) @(negedge clk);
    check_full_run("run2");
    bus_read(3'd2, 32'h1);
    bus_write(3'd1, 32'h2);

    // Reset during WAIT of bit 5
    clear_model();
    bus_write(3'd0, 32'h1);
    repeat (123) @(negedge clk);
    check("b5_fires", 64'(fire_cnt), 64'd6);
    check("b5_chal", puf_challenge, 64'h20);
    reset = 1'b1;
    #1;
    check("mid_rst_start", {63'd0, puf_start}, 64'd0);
    check("mid_rst_chal", puf_challenge, 64'd0);
    check("mid_rst_irq", {63'd0, irq}, 64'd0);
    check("mid_rst_rvalid", {63'd0, bus.avs_readdatavalid}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus_read(3'd1, 32'h0);
    bus_read(3'd4, 32'h0);
    bus_read(3'd2, 32'h0);
    clear_model();
    bus_write(3'd2, 32'h1);
    bus_write(3'd0, 32'h1);
    repeat (c_RUN) @(negedge clk);
    check_full_run("run3");

    repeat (4) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
